// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding,
// STATUS field positions and the handler-address helper.
package int_ctrl_pkg;

    localparam int ID_W = 4;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int STAT_STATE_LSB = 8;
    localparam int STAT_ID_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    // Handler address wraps modulo 2^32 by construction of the 32-bit result.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [ID_W-1:0] id);
        return base + stride * 32'(id);
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Core-facing bus of the interrupt controller: sources, acknowledge,
// register access and the vectored request outputs.
interface int_ctrl_if #(
    parameter int unsigned N_IRQ = 4
);
    logic [N_IRQ-1:0] irq_in;
    logic             iack;
    logic             we;
    logic [1:0]       addr;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic             irq;
    logic [31:0]      EAddr;

    modport master (
        output irq_in, iack, we, addr, wd,
        input  rd, irq, EAddr
    );

    modport slave (
        input  irq_in, iack, we, addr, wd,
        output rd, irq, EAddr
    );
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest-numbered one.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ = 4
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: per-channel synchroniser, edge/level pending
// logic, mask/mode registers and the IDLE/REQ/SERV request handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input logic       clk,
    input logic       rst,
    int_ctrl_if.slave bus
);

    logic [N_IRQ-1:0] s1_q, s2_q, s3_q, pend_q, mask_q, mode_q;
    logic [N_IRQ-1:0] s1_d, s2_d, s3_d, pend_d, mask_d, mode_d;
    state_t           state_q, state_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;

    logic             enc_valid;
    logic [ID_W-1:0]  enc_idx;
    logic             wr_mask, wr_pend, wr_mode, wr_eoi, ack_take;
    logic             unused_wd;

    assign wr_mask   = bus.we && (bus.addr == ADDR_MASK);
    assign wr_pend   = bus.we && (bus.addr == ADDR_PEND);
    assign wr_mode   = bus.we && (bus.addr == ADDR_MODE);
    assign wr_eoi    = bus.we && (bus.addr == ADDR_STAT);
    assign ack_take  = (state_q == ST_REQ) && bus.iack;
    assign unused_wd = ^bus.wd[31:N_IRQ];

    always_comb begin
        s1_d   = bus.irq_in;
        s2_d   = s1_q;
        s3_d   = s2_q;
        mask_d = wr_mask ? bus.wd[N_IRQ-1:0] : mask_q;
        mode_d = wr_mode ? bus.wd[N_IRQ-1:0] : mode_q;
    end

    // Edge channels: a fresh edge beats a same-cycle software or iack clear.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
        logic edge_set, edge_clr;
        assign edge_set   = s2_q[gi] & ~s3_q[gi];
        assign edge_clr   = (wr_pend & bus.wd[gi]) | (ack_take & (cur_id_q == ID_W'(gi)));
        assign pend_d[gi] = mode_q[gi] ? (edge_set | (pend_q[gi] & ~edge_clr)) : s2_q[gi];
    end

    int_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req   (pend_q & mask_q),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d  = ST_REQ;
                    cur_id_d = enc_idx;
                end
            end
            ST_REQ: begin
                if (bus.iack) begin
                    state_d = ST_SERV;
                end
            end
            ST_SERV: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= '0;
            state_q  <= ST_IDLE;
            cur_id_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
        end
    end

    assign bus.irq   = (state_q == ST_REQ);
    assign bus.EAddr = vec_addr(VEC_BASE, VEC_STRIDE, cur_id_q);

    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            ADDR_MASK: bus.rd[N_IRQ-1:0] = mask_q;
            ADDR_PEND: bus.rd[N_IRQ-1:0] = pend_q;
            ADDR_MODE: bus.rd[N_IRQ-1:0] = mode_q;
            default: begin
                bus.rd[STAT_STATE_LSB +: 2]  = state_q;
                bus.rd[STAT_ID_LSB +: ID_W]  = cur_id_q;
            end
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Randomised scoreboard bench for int_ctrl: stimulus pushes expected handler
// addresses and register reads, a negedge monitor pops and compares them.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int          N      = 4;
    localparam logic [31:0] BASE   = 32'h0000_0180;
    localparam logic [31:0] STRIDE = 32'h0000_0010;
    localparam logic [31:0] ALL    = 32'h0000_000F;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int_ctrl_if #(.N_IRQ(N)) bus ();

    int_ctrl #(
        .N_IRQ      (N),
        .VEC_BASE   (BASE),
        .VEC_STRIDE (STRIDE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_req_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        rd_strobe    = 1'b0;
    logic        mon_irq_prev = 1'b0;

    function automatic logic [31:0] model_eaddr(input int ch);
        return BASE + STRIDE * 32'(ch);
    endfunction

    function automatic logic [31:0] stat_word(input state_t s, input int ch);
        return (32'(s) << 8) | 32'(ch);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compares every new request and every strobed register read.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rd_strobe) begin
                chk(rd_name_q.pop_front(), bus.rd, rd_exp_q.pop_front());
            end
            if (!rst && bus.irq && !mon_irq_prev) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_irq: got request EAddr=%h required none", bus.EAddr);
                end else begin
                    e = exp_req_q.pop_front();
                    $display("req   EAddr=%h expected=%h", bus.EAddr, e);
                    chk("req_eaddr", bus.EAddr, e);
                end
            end
            mon_irq_prev = bus.irq;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        tick();
        bus.we   = 1'b0;
        bus.wd   = '0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        rd_strobe = 1'b1;
        @(negedge clk);
        #1;
        rd_strobe = 1'b0;
        tick();
    endtask

    task automatic pulse_iack();
        bus.iack = 1'b1;
        tick();
        bus.iack = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!bus.irq && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.irq) begin
            failures++;
            $display("FAIL %s: irq low after %0d cycles, required high", name, n);
        end
    endtask

    task automatic serve(input int ch, input bit poke, input logic [N-1:0] m);
        wait_irq("wait_irq");
        if (poke) begin
            wr(ADDR_MASK, 32'h0);
            wr(ADDR_STAT, $urandom);
            chk("irq_held", 32'(bus.irq), 32'd1);
            chk("eaddr_held", bus.EAddr, model_eaddr(ch));
            wr(ADDR_MASK, 32'(m));
        end
        rd_check("status_req", ADDR_STAT, stat_word(ST_REQ, ch));
        pulse_iack();
        chk("irq_after_iack", 32'(bus.irq), 32'd0);
        rd_check("status_serv", ADDR_STAT, stat_word(ST_SERV, ch));
        wr(ADDR_STAT, $urandom);
    endtask

    task automatic edge_episode(input logic [N-1:0] s, input logic [N-1:0] m, input bit poke);
        int order[$];
        wr(ADDR_MODE, ALL);
        wr(ADDR_MASK, 32'(m));
        for (int i = 0; i < N; i++) if (s[i] && m[i]) order.push_back(i);
        foreach (order[j]) exp_req_q.push_back(model_eaddr(order[j]));
        bus.irq_in = s;
        repeat (3) tick();
        bus.irq_in = '0;
        foreach (order[j]) serve(order[j], poke && (j == 0), m);
        repeat (6) tick();
        rd_check("pend_masked", ADDR_PEND, 32'(s & ~m));
        order.delete();
        for (int i = 0; i < N; i++) if (s[i] && !m[i]) order.push_back(i);
        foreach (order[j]) exp_req_q.push_back(model_eaddr(order[j]));
        wr(ADDR_MASK, ALL);
        foreach (order[j]) serve(order[j], 1'b0, '1);
        repeat (6) tick();
        rd_check("pend_clear", ADDR_PEND, 32'h0);
    endtask

    task automatic level_episode(input int c);
        wr(ADDR_MODE, 32'h0);
        wr(ADDR_MASK, ALL);
        exp_req_q.push_back(model_eaddr(c));
        exp_req_q.push_back(model_eaddr(c));
        bus.irq_in[c] = 1'b1;
        wait_irq("lvl_irq");
        rd_check("lvl_pend", ADDR_PEND, 32'd1 << c);
        wr(ADDR_PEND, ALL);
        rd_check("lvl_pend_w1c_ignored", ADDR_PEND, 32'd1 << c);
        pulse_iack();
        rd_check("lvl_status_serv", ADDR_STAT, stat_word(ST_SERV, c));
        wr(ADDR_STAT, $urandom);
        wait_irq("lvl_rereq");
        rd_check("lvl_status_req", ADDR_STAT, stat_word(ST_REQ, c));
        pulse_iack();
        bus.irq_in[c] = 1'b0;
        repeat (5) tick();
        rd_check("lvl_pend_drop", ADDR_PEND, 32'h0);
        wr(ADDR_STAT, $urandom);
        repeat (5) tick();
    endtask

    initial begin
        logic [N-1:0] rs, rm;
        bus.irq_in = '0;
        bus.iack   = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = 2'd0;
        bus.wd     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_eaddr", bus.EAddr, 32'h0000_0180);
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            chk("rst_reg", bus.rd, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Three-edge latency and channel 2 vector
        wr(ADDR_MODE, ALL);
        wr(ADDR_MASK, ALL);
        exp_req_q.push_back(model_eaddr(2));
        bus.irq_in = 4'b0100;
        tick();
        chk("lat_k0", 32'(bus.irq), 32'd0);
        tick();
        tick();
        chk("lat_k2", 32'(bus.irq), 32'd0);
        tick();
        chk("lat_k3", 32'(bus.irq), 32'd1);
        chk("eaddr_ch2", bus.EAddr, 32'h0000_01A0);
        bus.irq_in = '0;
        pulse_iack();
        chk("iack_irq_low", 32'(bus.irq), 32'd0);
        rd_check("iack_pend_clr", ADDR_PEND, 32'h0);
        wr(ADDR_STAT, 32'h0);

        // Simultaneous channels 3 and 1, then masked pulse enabled later
        edge_episode(4'b1010, 4'b1111, 1'b0);
        edge_episode(4'b0001, 4'b0000, 1'b0);

        // PEND clear coinciding with a new edge: the set wins
        wr(ADDR_MODE, ALL);
        wr(ADDR_MASK, 32'h0);
        bus.irq_in = 4'b1000;
        tick();
        tick();
        bus.we   = 1'b1;
        bus.addr = ADDR_PEND;
        bus.wd   = 32'h8;
        tick();
        bus.we   = 1'b0;
        bus.wd   = '0;
        rd_check("w1c_set_wins", ADDR_PEND, 32'h8);
        wr(ADDR_PEND, 32'h8);
        rd_check("w1c_clear", ADDR_PEND, 32'h0);
        bus.irq_in = '0;
        repeat (4) tick();
        rd_check("fall_no_set", ADDR_PEND, 32'h0);

        // Level source held across service re-requests
        level_episode(1);

        // Randomised episodes
        repeat (24) begin
            if ($urandom_range(0, 2) == 0) begin
                level_episode(int'($urandom_range(0, N - 1)));
            end else begin
                rs = N'($urandom_range(1, 15));
                rm = N'($urandom_range(0, 15));
                edge_episode(rs, rm, 1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset while in SERV
        wr(ADDR_MODE, ALL);
        wr(ADDR_MASK, ALL);
        exp_req_q.push_back(model_eaddr(2));
        bus.irq_in = 4'b0100;
        repeat (3) tick();
        bus.irq_in = '0;
        wait_irq("pre_rst_irq");
        pulse_iack();
        rd_check("pre_rst_status", ADDR_STAT, stat_word(ST_SERV, 2));
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_irq", 32'(bus.irq), 32'd0);
        chk("midrst_eaddr", bus.EAddr, 32'h0000_0180);
        bus.addr = ADDR_STAT;
        #1;
        chk("midrst_status", bus.rd, 32'h0);
        bus.addr = ADDR_MASK;
        #1;
        chk("midrst_mask", bus.rd, 32'h0);
        bus.addr = ADDR_MODE;
        #1;
        chk("midrst_mode", bus.rd, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick();
        rd_check("post_rst_status", ADDR_STAT, 32'h0);

        chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
